// File: rtl/bwe_train_probe.sv
// Bandwidth-estimation probe-train monitor.
// Measures the receive-side inter-packet delays (IPDs) of one probe train per
// run. It reports min/max/sum of the IPDs, how many were at/above versus below
// the sender IPD, and a congestion verdict. A lost-packet timeout ends a run
// early when the next packet never arrives.
module bwe_train_probe #(
    parameter int TIMER_W  = 16,
    parameter int MAX_PKTS = 8,
    parameter int PKT_W    = $clog2(MAX_PKTS + 1),
    parameter int SUM_W    = TIMER_W + PKT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [TIMER_W-1:0] cfg_sender_ipd,
    input  logic [PKT_W-1:0]   cfg_train_len,
    input  logic [TIMER_W-1:0] cfg_timeout,
    input  logic [PKT_W-1:0]   cfg_cong_thresh,
    input  logic               pkt_arrival,
    output logic               busy,
    output logic               done,
    output logic               timed_out,
    output logic [PKT_W-1:0]   ge_count,
    output logic [PKT_W-1:0]   lt_count,
    output logic [TIMER_W-1:0] ipd_min,
    output logic [TIMER_W-1:0] ipd_max,
    output logic [SUM_W-1:0]   ipd_sum,
    output logic               congested
);

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_WAIT_FIRST = 2'd1;
    localparam logic [1:0] S_MEASURE    = 2'd2;
    localparam logic [1:0] S_DONE       = 2'd3;

    localparam logic [PKT_W-1:0]   MAX_LEN  = PKT_W'(MAX_PKTS);
    localparam logic [PKT_W-1:0]   ONE_PKT  = PKT_W'(1);
    localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);

    // The timer must not wrap: a wrapped value would look like a short IPD.
    function automatic logic [TIMER_W-1:0] sat_inc(input logic [TIMER_W-1:0] v);
        logic [TIMER_W-1:0] r;
        if (v == {TIMER_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + TIMER_ONE;
        end
        return r;
    endfunction

    // Over-long trains are clamped so the counters can never exceed MAX_PKTS.
    function automatic logic [PKT_W-1:0] clamp_len(input logic [PKT_W-1:0] v);
        logic [PKT_W-1:0] r;
        if (v > MAX_LEN) begin
            r = MAX_LEN;
        end else begin
            r = v;
        end
        return r;
    endfunction

    logic [1:0]         state;
    logic [1:0]         state_next;

    logic [TIMER_W-1:0] sender_ipd_q;
    logic [TIMER_W-1:0] timeout_q;
    logic [PKT_W-1:0]   train_len_q;
    logic [PKT_W-1:0]   thresh_q;

    logic [TIMER_W-1:0] timer;
    logic [PKT_W-1:0]   pkt_cnt;

    logic               accept_start;
    logic               first_arr;
    logic               first_only;
    logic               meas_arr;
    logic               meas_last;
    logic               meas_tmo;
    logic               enter_done;
    logic               sample_ge;
    logic               timeout_hit;
    logic [PKT_W-1:0]   pkt_cnt_inc;
    logic [PKT_W-1:0]   ge_final;

    // Decode the events that drive the FSM and the result datapath.
    always_comb begin
        accept_start = (state == S_IDLE) && start;
        first_arr    = (state == S_WAIT_FIRST) && pkt_arrival;
        first_only   = first_arr && (train_len_q <= ONE_PKT);
        meas_arr     = (state == S_MEASURE) && pkt_arrival;
        pkt_cnt_inc  = pkt_cnt + ONE_PKT;
        meas_last    = meas_arr && (pkt_cnt_inc == train_len_q);
        timeout_hit  = (timeout_q != '0) && (timer == timeout_q);
        meas_tmo     = (state == S_MEASURE) && !pkt_arrival && timeout_hit;
        enter_done   = first_only || meas_last || meas_tmo;
        sample_ge    = (timer >= sender_ipd_q);
        ge_final     = (meas_arr && sample_ge) ? (ge_count + ONE_PKT) : ge_count;
    end

    // Next-state logic; an arrival outranks a coincident timeout.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_WAIT_FIRST;
                end
            end
            S_WAIT_FIRST: begin
                if (pkt_arrival) begin
                    state_next = first_only ? S_DONE : S_MEASURE;
                end
            end
            S_MEASURE: begin
                if (meas_last || meas_tmo) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Per-run configuration, captured only when a start is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            sender_ipd_q <= '0;
            timeout_q    <= '0;
            train_len_q  <= '0;
            thresh_q     <= '0;
        end else if (accept_start) begin
            sender_ipd_q <= cfg_sender_ipd;
            timeout_q    <= cfg_timeout;
            train_len_q  <= clamp_len(cfg_train_len);
            thresh_q     <= cfg_cong_thresh;
        end
    end

    // IPD timer and packet counter: the timer reads k on an arrival k cycles
    // after the previous one, so it reloads 1 on every accepted arrival.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer   <= '0;
            pkt_cnt <= '0;
        end else if (accept_start) begin
            timer   <= '0;
            pkt_cnt <= '0;
        end else if (first_arr && !first_only) begin
            timer   <= TIMER_ONE;
            pkt_cnt <= ONE_PKT;
        end else if (meas_arr) begin
            timer   <= TIMER_ONE;
            pkt_cnt <= pkt_cnt_inc;
        end else if (state == S_MEASURE) begin
            timer   <= sat_inc(timer);
        end
    end

    // IPD statistics; cleared on start and held after the run until the next start.
    always_ff @(posedge clk) begin
        if (rst || accept_start) begin
            ge_count <= '0;
            lt_count <= '0;
            ipd_min  <= '1;
            ipd_max  <= '0;
            ipd_sum  <= '0;
        end else if (meas_arr) begin
            if (sample_ge) begin
                ge_count <= ge_count + ONE_PKT;
            end else begin
                lt_count <= lt_count + ONE_PKT;
            end
            if (timer < ipd_min) begin
                ipd_min <= timer;
            end
            if (timer > ipd_max) begin
                ipd_max <= timer;
            end
            ipd_sum <= ipd_sum + SUM_W'(timer);
        end
    end

    // Run-end flags, registered on entry to DONE so they are valid with the done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            done      <= 1'b0;
            timed_out <= 1'b0;
            congested <= 1'b0;
        end else begin
            done <= enter_done;
            if (accept_start) begin
                timed_out <= 1'b0;
                congested <= 1'b0;
            end else if (enter_done) begin
                timed_out <= meas_tmo;
                congested <= (ge_final >= thresh_q);
            end
        end
    end

    assign busy = (state == S_WAIT_FIRST) || (state == S_MEASURE);

endmodule

// File: tb/tb_bwe_train_probe.sv
// Scoreboard bench for bwe_train_probe: stimulus pushes the expected result of
// each run; a monitor pops and compares whenever done pulses.
module tb_bwe_train_probe;

    localparam int TIMER_W  = 16;
    localparam int MAX_PKTS = 8;
    localparam int PKT_W    = 4;
    localparam int SUM_W    = 20;

    logic               clk;
    logic               rst;
    logic               start;
    logic [TIMER_W-1:0] cfg_sender_ipd;
    logic [PKT_W-1:0]   cfg_train_len;
    logic [TIMER_W-1:0] cfg_timeout;
    logic [PKT_W-1:0]   cfg_cong_thresh;
    logic               pkt_arrival;
    logic               busy;
    logic               done;
    logic               timed_out;
    logic [PKT_W-1:0]   ge_count;
    logic [PKT_W-1:0]   lt_count;
    logic [TIMER_W-1:0] ipd_min;
    logic [TIMER_W-1:0] ipd_max;
    logic [SUM_W-1:0]   ipd_sum;
    logic               congested;

    bwe_train_probe #(
        .TIMER_W (TIMER_W),
        .MAX_PKTS(MAX_PKTS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .cfg_sender_ipd (cfg_sender_ipd),
        .cfg_train_len  (cfg_train_len),
        .cfg_timeout    (cfg_timeout),
        .cfg_cong_thresh(cfg_cong_thresh),
        .pkt_arrival    (pkt_arrival),
        .busy           (busy),
        .done           (done),
        .timed_out      (timed_out),
        .ge_count       (ge_count),
        .lt_count       (lt_count),
        .ipd_min        (ipd_min),
        .ipd_max        (ipd_max),
        .ipd_sum        (ipd_sum),
        .congested      (congested)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    to;
        int    ge;
        int    lt;
        int    mn;
        int    mx;
        int    sum;
        int    cong;
        int    cyc;
    } exp_t;

    exp_t sb[$];
    int   gq[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    exp_t mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic exp_t mk(input string tag, input int to, input int ge, input int lt,
                                input int mn, input int mx, input int sum, input int cong);
        exp_t e;
        e.tag = tag; e.to = to; e.ge = ge; e.lt = lt;
        e.mn = mn; e.mx = mx; e.sum = sum; e.cong = cong; e.cyc = 0;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", done, 0);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.tag, ".done_cycle"}, cyc, mon_e.cyc);
                check({mon_e.tag, ".timed_out"}, timed_out, mon_e.to);
                check({mon_e.tag, ".ge_count"}, ge_count, mon_e.ge);
                check({mon_e.tag, ".lt_count"}, lt_count, mon_e.lt);
                check({mon_e.tag, ".ipd_min"}, ipd_min, mon_e.mn);
                check({mon_e.tag, ".ipd_max"}, ipd_max, mon_e.mx);
                check({mon_e.tag, ".ipd_sum"}, ipd_sum, mon_e.sum);
                check({mon_e.tag, ".congested"}, congested, mon_e.cong);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Arrival k cycles after the previous one (k >= 1).
    task automatic pulse_after(input int k);
        repeat (k - 1) tick();
        pkt_arrival = 1'b1;
        tick();
        pkt_arrival = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300 && sb.size() != 0; i++) tick();
        if (sb.size() != 0) begin
            check("done_wait_bound", sb.size(), 0);
            sb.delete();
        end
        tick();
        tick();
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".done"}, done, 0);
        check({tag, ".timed_out"}, timed_out, 0);
        check({tag, ".ge_count"}, ge_count, 0);
        check({tag, ".lt_count"}, lt_count, 0);
        check({tag, ".ipd_min"}, ipd_min, 16'hFFFF);
        check({tag, ".ipd_max"}, ipd_max, 0);
        check({tag, ".ipd_sum"}, ipd_sum, 0);
        check({tag, ".congested"}, congested, 0);
    endtask

    task automatic set_cfg(input int s, input int len, input int tmo, input int th);
        cfg_sender_ipd  = TIMER_W'(s);
        cfg_train_len   = PKT_W'(len);
        cfg_timeout     = TIMER_W'(tmo);
        cfg_cong_thresh = PKT_W'(th);
    endtask

    // One run: start, first arrival, then arrivals at the gaps held in gq.
    // offset is the expected done cycle relative to the first arrival edge.
    task automatic run(input int s, input int len, input int tmo, input int th,
                       input exp_t e, input int offset);
        exp_t ex;
        ex = e;
        set_cfg(s, len, tmo, th);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({e.tag, ".busy_after_start"}, busy, 1);
        pkt_arrival = 1'b1;
        tick();
        pkt_arrival = 1'b0;
        ex.cyc = cyc + offset;
        sb.push_back(ex);
        foreach (gq[i]) pulse_after(gq[i]);
        gq.delete();
        wait_done();
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        pkt_arrival = 1'b0;
        set_cfg(0, 0, 0, 0);
        tick();
        tick();
        check_reset("por");
        rst = 1'b0;
        tick();

        // Nominal train, all IPDs above sender IPD.
        gq = '{12, 11, 17};
        run(10, 4, 0, 3, mk("t1", 0, 3, 0, 11, 17, 40, 1), 40);

        // Boundary IPD equal to sender IPD counts as ge; back-to-back gives 1.
        gq = '{10, 9, 1};
        run(10, 4, 0, 2, mk("t2", 0, 1, 2, 1, 10, 20, 0), 20);

        // Lost packet: timeout 20 cycles after the second arrival.
        gq = '{5};
        run(4, 3, 20, 1, mk("t3", 1, 1, 0, 5, 5, 5, 1), 25);

        // Arrival exactly on the timeout cycle wins.
        gq = '{5, 20};
        run(4, 3, 20, 3, mk("t3b", 0, 2, 0, 5, 20, 25, 0), 25);

        // Reset mid-MEASURE: no done, outputs back to reset values.
        set_cfg(10, 4, 0, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        pkt_arrival = 1'b1;
        tick();
        pkt_arrival = 1'b0;
        repeat (5) tick();
        check("rst_mid.busy_before", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset("rst_mid");
        repeat (20) tick();
        check("rst_mid.still_idle", busy, 0);

        // Clean run after the aborted one.
        gq = '{2, 3};
        run(3, 3, 0, 2, mk("t4b", 0, 1, 1, 2, 3, 5, 0), 5);

        // start with a coincident arrival, then a start while busy.
        set_cfg(5, 3, 0, 1);
        start = 1'b1;
        pkt_arrival = 1'b1;
        tick();
        start = 1'b0;
        pkt_arrival = 1'b0;
        check("t5.busy_after_start", busy, 1);
        repeat (2) tick();
        pkt_arrival = 1'b1;
        tick();
        pkt_arrival = 1'b0;
        mon_e = mk("t5", 0, 1, 1, 4, 6, 10, 1);
        mon_e.cyc = cyc + 10;
        sb.push_back(mon_e);
        repeat (2) tick();
        set_cfg(100, 2, 0, 5);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t5.busy_after_restart", busy, 1);
        repeat (2) tick();
        pkt_arrival = 1'b1;
        tick();
        pkt_arrival = 1'b0;
        pulse_after(4);
        wait_done();

        // Single-packet train: done right after the first arrival, no samples.
        gq.delete();
        run(10, 1, 0, 1, mk("t6", 0, 0, 0, 65535, 0, 0, 0), 0);

        // Train length 15 clamps to 8: seven samples 1..7.
        gq = '{1, 2, 3, 4, 5, 6, 7};
        run(4, 15, 0, 4, mk("t7", 0, 4, 3, 1, 7, 28, 1), 28);

        // Results hold after the run.
        repeat (5) tick();
        check("t7.hold_sum", ipd_sum, 28);
        check("t7.hold_ge", ge_count, 4);

        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
